// File: rtl/hld_ctrl_gen_pkg.sv
// hld_ctrl_gen_pkg: shared FSM state, mode encoding and counter width for the hold-control generator
package hld_ctrl_gen_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
    localparam logic MODE_DIV = 1'b0;
    localparam logic MODE_DIR = 1'b1;
    localparam int HLD_CNT_W = 16;
endpackage

// File: rtl/hld_phase_cnt.sv
// hld_phase_cnt: modulo 2^W phase counter with clear, enable and wrap flag
module hld_phase_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         wrap
);
    assign wrap = inc && (q == {W{1'b1}});
    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (inc) q <= q + 1'b1;
    end
endmodule

// File: rtl/hld_ctrl_gen.sv
// hld_ctrl_gen: staggered one-cycle hold pulses with period-aligned mode switching
module hld_ctrl_gen
    import hld_ctrl_gen_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int NCH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 M,
    input  logic                 DIV_M,
    output logic [NCH-1:0]       Ctrl_HLD,
    output logic [CNT_W-1:0]     phase,
    output logic                 mode_act,
    output logic [HLD_CNT_W-1:0] hld_cnt
);
    state_t           state;
    logic             wrap;
    logic [CNT_W-1:0] base;
    logic [NCH-1:0]   hit;
    hld_phase_cnt #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE || !en),
        .inc  (state != IDLE),
        .q    (phase),
        .wrap (wrap)
    );
    assign base = mode_act == MODE_DIR ? {{(CNT_W-1){1'b1}}, 1'b0} : {CNT_W{1'b1}};
    always_comb begin
        hit = '0;
        for (int i = 0; i < NCH; i++)
            hit[i] = state != IDLE && en && phase == base - CNT_W'(i) && !(mode_act == MODE_DIV && DIV_M);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            Ctrl_HLD <= '0;
            mode_act <= MODE_DIV;
            hld_cnt  <= '0;
        end else begin
            Ctrl_HLD <= hit;
            if (hit[0]) hld_cnt <= hld_cnt + 1'b1;
            if (!en) state <= IDLE;
            else if (state == IDLE) state <= RUN;
            else if (state == RUN) state <= M != mode_act ? PEND : RUN;
            else if (wrap) begin
                mode_act <= M;
                state    <= RUN;
            end else if (M == mode_act) state <= RUN;
        end
    end
endmodule

// File: tb/tb_hld_ctrl_gen.sv
// tb_hld_ctrl_gen: directed and random stimulus on two configurations against a behavioural model
module tb_hld_ctrl_gen;
    import hld_ctrl_gen_pkg::*;
    logic clk = 0, rst = 1, en = 0, m = 0, div_m = 0;
    logic [1:0] hld0, ph0;
    logic [7:0] hld1;
    logic [2:0] ph1;
    logic ma0, ma1;
    logic [15:0] cnt0, cnt1;
    int checks = 0, failures = 0;
    int mp[2] = '{4, 8};
    int mn[2] = '{2, 8};
    state_t ms[2];
    int mph[2], mma[2], mcnt[2], mhld[2];
    logic [7:0] acc;
    always #5 clk = ~clk;
    hld_ctrl_gen #(.CNT_W(2), .NCH(2)) dut0 (
        .clk(clk), .rst(rst), .en(en), .M(m), .DIV_M(div_m),
        .Ctrl_HLD(hld0), .phase(ph0), .mode_act(ma0), .hld_cnt(cnt0)
    );
    hld_ctrl_gen #(.CNT_W(3), .NCH(8)) dut1 (
        .clk(clk), .rst(rst), .en(en), .M(m), .DIV_M(div_m),
        .Ctrl_HLD(hld1), .phase(ph1), .mode_act(ma1), .hld_cnt(cnt1)
    );
    function automatic void model_step(int k);
        int p = mp[k];
        int base, h = 0;
        if (rst) begin
            ms[k] = IDLE; mph[k] = 0; mhld[k] = 0; mma[k] = 0; mcnt[k] = 0;
            return;
        end
        base = mma[k] ? p - 2 : p - 1;
        for (int i = 0; i < mn[k]; i++)
            if (ms[k] != IDLE && en && mph[k] == (base - i + p) % p && !(mma[k] == 0 && div_m))
                h |= 1 << i;
        mhld[k] = h;
        if (h & 1) mcnt[k] = (mcnt[k] + 1) % 65536;
        if (!en) begin
            ms[k] = IDLE; mph[k] = 0;
        end else if (ms[k] == IDLE) begin
            ms[k] = RUN; mph[k] = 0;
        end else begin
            if (ms[k] == RUN) ms[k] = (int'(m) != mma[k]) ? PEND : RUN;
            else if (mph[k] == p - 1) begin mma[k] = int'(m); ms[k] = RUN; end
            else if (int'(m) == mma[k]) ms[k] = RUN;
            mph[k] = (mph[k] + 1) % p;
        end
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        chk("hld0", 32'(hld0), mhld[0]);
        chk("ph0", 32'(ph0), mph[0]);
        chk("ma0", 32'(ma0), mma[0]);
        chk("cnt0", 32'(cnt0), mcnt[0]);
        chk("st0", 32'(dut0.state), 32'(ms[0]));
        chk("hld1", 32'(hld1), mhld[1]);
        chk("ph1", 32'(ph1), mph[1]);
        chk("ma1", 32'(ma1), mma[1]);
        chk("cnt1", 32'(cnt1), mcnt[1]);
        chk("st1", 32'(dut1.state), 32'(ms[1]));
    endtask
    initial begin
        repeat (3) cyc();
        chk("rst_hld", 32'(hld0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_st", 32'(dut0.state), 32'(IDLE));
        rst = 0; en = 1;
        repeat (13) cyc();
        chk("cnt_3per", 32'(cnt0), 3);
        for (int t = 0; t < 16 && mph[0] != 1; t++) cyc();
        chk("sync_ph1", 32'(ph0), 1);
        m = 1;
        cyc();
        chk("pend", 32'(dut0.state), 32'(PEND));
        cyc();
        chk("no_mid_switch", 32'(ma0), 0);
        cyc();
        chk("switch_at_wrap", 32'(ma0), 1);
        chk("wrap_ph0", 32'(ph0), 0);
        cyc(); cyc();
        chk("dir_ch1", 32'(hld0), 2);
        cyc();
        chk("dir_ch0", 32'(hld0), 1);
        m = 0;
        cyc();
        m = 1;
        cyc();
        chk("toggle_ma", 32'(ma0), 1);
        chk("toggle_st", 32'(dut0.state), 32'(RUN));
        m = 0;
        cyc();
        chk("pend_ph2", 32'(ph0), 2);
        rst = 1;
        cyc();
        chk("rstp_hld", 32'(hld0), 0);
        chk("rstp_ph", 32'(ph0), 0);
        chk("rstp_ma", 32'(ma0), 0);
        chk("rstp_st", 32'(dut0.state), 32'(IDLE));
        rst = 0; div_m = 0;
        cyc();
        acc = '0;
        for (int j = 0; j < 8; j++) begin
            cyc();
            chk("stagger", 32'(hld1), 32'(8'h80 >> j));
            acc |= hld1;
        end
        chk("all_ch", 32'(acc), 32'hFF);
        div_m = 1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("divm_sup", 32'(hld0), 0);
        end
        div_m = 0;
        repeat (400) begin
            rst = $urandom_range(0, 99) == 0;
            en = $urandom_range(0, 19) != 0;
            if ($urandom_range(0, 9) == 0) m = ~m;
            div_m = $urandom_range(0, 2) == 0;
            cyc();
        end
        rst = 1; m = 0; div_m = 0; en = 1;
        cyc();
        rst = 0;
        repeat (3) cyc();
        force dut0.hld_cnt = 16'hFFFE;
        force dut1.hld_cnt = 16'hFFFE;
        #1;
        release dut0.hld_cnt;
        release dut1.hld_cnt;
        mcnt[0] = 65534;
        mcnt[1] = 65534;
        repeat (8) cyc();
        chk("cnt_wrap0", 32'(cnt0), 0);
        chk("cnt_wrap1", 32'(cnt1), 32'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hld_ctrl_gen.md
HLD_CTRL_GEN -- requirements
Module: hld_ctrl_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 2, giving the width of the phase counter; period P = 2^CNT_W cycles; legal range 2..8.
REQ-002 The block SHALL have parameter NCH, default 2, giving the number of staggered hold-control channels; legal range 1..P.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: run enable.
REQ-006 The block SHALL have port M, input, 1 bit: mode request (0 = divided-mode hold, 1 = direct-mode hold).
REQ-007 The block SHALL have port DIV_M, input, 1 bit: hold inhibit, honoured in mode 0 only.
REQ-008 The block SHALL have port Ctrl_HLD, output, NCH bits: registered one-cycle hold pulses, one bit per channel.
REQ-009 The block SHALL have port phase, output, CNT_W bits: current phase-counter value.
REQ-010 The block SHALL have port mode_act, output, 1 bit: the mode currently in force.
REQ-011 The block SHALL have port hld_cnt, output, 16 bits: count of channel-0 pulses issued.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and PEND.
REQ-013 From IDLE the FSM SHALL go to RUN when en=1; phase SHALL be held at 0 in IDLE.
REQ-014 From RUN the FSM SHALL go to PEND when M != mode_act; from RUN or PEND it SHALL go to IDLE when en=0.
REQ-015 In PEND, on the cycle phase wraps from P-1 to 0, the FSM SHALL load mode_act <= M and return to RUN; a mode change SHALL never take effect mid-period.
REQ-016 If M returns to mode_act while in PEND, the FSM SHALL go back to RUN with no mode change.
REQ-017 In RUN and PEND, phase SHALL increment by 1 per cycle and wrap modulo P.
REQ-018 The base match value SHALL be P-1 when mode_act=0 and P-2 when mode_act=1.
REQ-019 Channel i SHALL match when phase == (base - i) mod P, with wrap-around below 0.
REQ-020 Ctrl_HLD[i] SHALL be 1 for exactly one cycle, the cycle after its match (latency 1, registered).
REQ-021 In mode 0, the block SHALL suppress the pulse when DIV_M, sampled on the match cycle, is 1; DIV_M SHALL be ignored in mode 1.
REQ-022 Pulses SHALL be generated in RUN and PEND, and never in IDLE.
REQ-023 Deasserting en SHALL clear Ctrl_HLD on the next cycle; any pulse already registered SHALL still complete.
REQ-024 hld_cnt SHALL increment on each Ctrl_HLD[0] pulse and wrap from 0xFFFF to 0.
REQ-025 At P=4 and NCH=1, the output SHALL equal a combinational hold of clk2/clk4 delayed by one cycle: mode 0 = clk2&clk4&~DIV_M; mode 1 = clk4&~clk2.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set state=IDLE, phase=0, Ctrl_HLD=0, mode_act=0 and hld_cnt=0.
REQ-027 Reset SHALL take priority over en, M and any pending mode change.
REQ-028 Reset mid-PEND SHALL discard the pending change.
REQ-029 The first pulse after reset release SHALL follow the normal latency rules starting from phase 0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE/RUN/PEND), the mode encoding constants, and the hld_cnt width constant (16).
REQ-031 One sub-module, hld_phase_cnt, SHALL implement the CNT_W modulo counter with clear, enable and a wrap flag; the FSM, match and pulse logic SHALL reside in the top module.

Verification
REQ-032 With CNT_W=2, NCH=2, M=0, DIV_M=0: release rst, set en=1 -> Ctrl_HLD[0] high the cycle after phase=3, Ctrl_HLD[1] high the cycle after phase=2, repeating every 4 cycles; hld_cnt=3 after 3 periods.
REQ-033 Mode 0 with DIV_M=1 held across the phase-3 match -> Ctrl_HLD[0] stays 0 for that period; Ctrl_HLD[1] is suppressed at its own match if DIV_M=1 there.
REQ-034 Set M=1 at phase=1 -> state=PEND, mode_act stays 0 until the phase wraps 3->0; the next Ctrl_HLD[0] follows phase=2.
REQ-035 Toggle M 0->1->0 within one period -> no mode change, and the pulse pattern is unchanged.
REQ-036 Assert rst during PEND at phase=2 -> next cycle all outputs are 0, state=IDLE, mode_act=0.
REQ-037 With CNT_W=3, NCH=8, mode 0 -> one pulse on each channel per 8 cycles, each channel one cycle earlier than the previous, channel 7 matching at phase 0; hld_cnt wraps correctly after 65536 pulses (forced-counter test).
